// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a fixed 8-step melody on a single buzzer pin using the
// four tone square waves coming from the divider bank.
// Ports:
//   clk_50MHz     system clock
//   reset_button  asynchronous active-low reset
//   clk_261Hz..clk_523Hz  tone square waves (registered internally)
//   play_button   raw active-high button, rising edge starts the melody
//   stop_button   raw active-high button, level aborts / blocks play
//   buzzer        selected tone or 0 when silent (registered)
//   busy          high while a note or gap is in progress (registered)
//   note_idx      current melody step 0..7 (registered)
//   done_pulse    one-cycle pulse on natural completion (registered)
module tone_sequencer #(
  parameter int unsigned TICK_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 500000
) (
  input  logic       clk_50MHz,
  input  logic       reset_button,
  input  logic       clk_261Hz,
  input  logic       clk_329Hz,
  input  logic       clk_415Hz,
  input  logic       clk_523Hz,
  input  logic       play_button,
  input  logic       stop_button,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] note_idx,
  output logic       done_pulse
);

  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [2:0] TONE_REST = 3'd4;
  localparam logic [2:0] LAST_IDX  = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, NOTE = 2'd1, GAP = 2'd2} state_t;

  // Melody tone select: 0=261, 1=329, 2=415, 3=523, 4=rest
  function automatic logic [2:0] rom_tone(input logic [2:0] idx);
    case (idx)
      3'd0: rom_tone = 3'd0;
      3'd1: rom_tone = 3'd1;
      3'd2: rom_tone = 3'd2;
      3'd3: rom_tone = 3'd3;
      3'd4: rom_tone = 3'd2;
      3'd5: rom_tone = 3'd1;
      3'd6: rom_tone = 3'd0;
      default: rom_tone = TONE_REST;
    endcase
  endfunction

  // Melody duration in 100 ms ticks
  function automatic logic [2:0] rom_ticks(input logic [2:0] idx);
    case (idx)
      3'd3, 3'd6: rom_ticks = 3'd4;
      default:    rom_ticks = 3'd2;
    endcase
  endfunction

  state_t            state, state_n;
  logic [1:0]        play_sync, stop_sync;
  logic              play_prev, play_edge;
  logic [3:0]        tone_r;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [2:0]        ticks_left, left_n;
  logic [2:0]        idx_n, sel_n;
  logic              buzzer_n, busy_n, done_n;
  logic              stop_s;

  assign stop_s = stop_sync[1];

  // Button synchronizers, registered play edge and tone sampling
  always_ff @(posedge clk_50MHz or negedge reset_button) begin
    if (!reset_button) begin
      play_sync <= '0;
      stop_sync <= '0;
      play_prev <= 1'b0;
      play_edge <= 1'b0;
      tone_r    <= '0;
    end else begin
      play_sync <= {play_sync[0], play_button};
      stop_sync <= {stop_sync[0], stop_button};
      play_prev <= play_sync[1];
      play_edge <= play_sync[1] & ~play_prev;
      tone_r    <= {clk_523Hz, clk_415Hz, clk_329Hz, clk_261Hz};
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_50MHz or negedge reset_button) begin
    if (!reset_button) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      gap_cnt    <= '0;
      ticks_left <= '0;
      note_idx   <= '0;
      buzzer     <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      gap_cnt    <= gap_n;
      ticks_left <= left_n;
      note_idx   <= idx_n;
      buzzer     <= buzzer_n;
      busy       <= busy_n;
      done_pulse <= done_n;
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_n = state;
    idx_n   = note_idx;
    tick_n  = tick_cnt;
    gap_n   = gap_cnt;
    left_n  = ticks_left;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (play_edge && !stop_s) begin
          state_n = NOTE;
          idx_n   = 3'd0;
          tick_n  = '0;
          left_n  = rom_ticks(3'd0);
        end
      end
      NOTE: begin
        if (stop_s) begin
          state_n = IDLE;
          idx_n   = 3'd0;
        end else if (tick_cnt == TICK_LAST) begin
          tick_n = '0;
          if (ticks_left == 3'd1) begin
            if (note_idx == LAST_IDX) begin
              state_n = IDLE;
              idx_n   = 3'd0;
              done_n  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_n = GAP;
              gap_n   = '0;
            end else begin
              idx_n  = note_idx + 3'd1;
              left_n = rom_ticks(note_idx + 3'd1);
            end
          end else begin
            left_n = ticks_left - 3'd1;
          end
        end else begin
          tick_n = tick_cnt + TICK_W'(1);
        end
      end
      GAP: begin
        if (stop_s) begin
          state_n = IDLE;
          idx_n   = 3'd0;
        end else if (gap_cnt == GAP_LAST) begin
          state_n = NOTE;
          idx_n   = note_idx + 3'd1;
          tick_n  = '0;
          left_n  = rom_ticks(note_idx + 3'd1);
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = 3'd0;
      end
    endcase

    // Outputs follow the next state so they line up with the state register
    busy_n   = (state_n != IDLE);
    sel_n    = rom_tone(idx_n);
    buzzer_n = (state_n == NOTE && sel_n != TONE_REST) ? tone_r[sel_n[1:0]] : 1'b0;
  end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

  localparam int TICK = 10;
  localparam int GAPC = 3;
  localparam int LEAD = 4;
  localparam int MEL_TICKS [8] = '{2, 2, 2, 4, 2, 2, 4, 2};
  localparam int MEL_TONE  [8] = '{0, 1, 2, 3, 2, 1, 0, 4};

  logic clk_50MHz = 1'b0;
  logic reset_button, play_button, stop_button;
  logic clk_261Hz, clk_329Hz, clk_415Hz, clk_523Hz;
  logic buzzer, busy, done_pulse;
  logic [2:0] note_idx;
  logic buzzer0, busy0, done0;
  logic [2:0] idx0;

  int total = 0;
  int bad = 0;
  logic [3:0] t_cur = '0, t_old1 = '0, t_old2 = '0;
  int tone_mode = 0;
  int pat_cnt = 0;

  typedef struct {
    bit busy;
    int idx;
    int sel;
    bit done;
  } exp_t;

  always #10 clk_50MHz = ~clk_50MHz;

  tone_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAPC)) dut (
    .clk_50MHz(clk_50MHz), .reset_button(reset_button),
    .clk_261Hz(clk_261Hz), .clk_329Hz(clk_329Hz), .clk_415Hz(clk_415Hz), .clk_523Hz(clk_523Hz),
    .play_button(play_button), .stop_button(stop_button),
    .buzzer(buzzer), .busy(busy), .note_idx(note_idx), .done_pulse(done_pulse)
  );

  tone_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(0)) dut0 (
    .clk_50MHz(clk_50MHz), .reset_button(reset_button),
    .clk_261Hz(clk_261Hz), .clk_329Hz(clk_329Hz), .clk_415Hz(clk_415Hz), .clk_523Hz(clk_523Hz),
    .play_button(play_button), .stop_button(stop_button),
    .buzzer(buzzer0), .busy(busy0), .note_idx(idx0), .done_pulse(done0)
  );

  // Expected sequencer view t cycles after the first NOTE cycle, walked from the melody table
  function automatic exp_t model_at(int gap, int t);
    exp_t e;
    int start;
    e.busy = 1'b0; e.idx = 0; e.sel = 4; e.done = 1'b0;
    start = 0;
    if (t < 0) return e;
    for (int s = 0; s < 8; s++) begin
      if (t < start + MEL_TICKS[s] * TICK) begin
        e.busy = 1'b1; e.idx = s; e.sel = MEL_TONE[s];
        return e;
      end
      start += MEL_TICKS[s] * TICK;
      if (s < 7) begin
        if (t < start + gap) begin
          e.busy = 1'b1; e.idx = s; e.sel = 4;
          return e;
        end
        start += gap;
      end
    end
    e.done = (t == start);
    return e;
  endfunction

  // Buzzer is the selected tone as it was sampled one edge before the current one
  function automatic logic exp_buzz(int sel);
    return (sel == 4) ? 1'b0 : t_old2[sel];
  endfunction

  task automatic step_cycle();
    @(posedge clk_50MHz);
    #1;
    t_old2 = t_old1;
    t_old1 = t_cur;
    if (tone_mode == 0) begin
      t_cur = 4'($urandom);
    end else begin
      pat_cnt++;
      t_cur = {1'($urandom), 1'(pat_cnt / 3), 1'(pat_cnt / 2), 1'(pat_cnt)};
    end
    {clk_523Hz, clk_415Hz, clk_329Hz, clk_261Hz} = t_cur;
    @(negedge clk_50MHz);
  endtask

  task automatic test_reset();
    reset_button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      play_button = 1'($urandom);
      stop_button = 1'($urandom);
      step_cycle();
      total++;
      if ({buzzer, busy, note_idx, done_pulse, buzzer0, busy0, idx0, done0} !== 12'h000) begin
        bad++;
        $display("FAIL reset_hold i=%0d got=%h required=000", i,
                 {buzzer, busy, note_idx, done_pulse, buzzer0, busy0, idx0, done0});
      end
    end
    play_button = 1'b0;
    stop_button = 1'b0;
    reset_button = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step_cycle();
      total++;
      if ({buzzer, busy, note_idx, done_pulse, buzzer0, busy0, idx0, done0} !== 12'h000) begin
        bad++;
        $display("FAIL reset_idle i=%0d got=%h required=000", i,
                 {buzzer, busy, note_idx, done_pulse, buzzer0, busy0, idx0, done0});
      end
    end
  endtask

  task automatic test_full_melody();
    exp_t e;
    int busy_cnt = 0;
    int done_cnt = 0;
    tone_mode = 0;
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 221 + 10; i++) begin
      step_cycle();
      if (i == 2) play_button = 1'b0;
      e = model_at(GAPC, i - LEAD);
      total++;
      if (busy !== e.busy || note_idx !== 3'(e.idx) || done_pulse !== e.done) begin
        bad++;
        $display("FAIL full_ctl i=%0d got busy=%b idx=%0d done=%b required busy=%b idx=%0d done=%b",
                 i, busy, note_idx, done_pulse, e.busy, e.idx, e.done);
      end
      total++;
      if (buzzer !== exp_buzz(e.sel)) begin
        bad++;
        $display("FAIL full_buzzer i=%0d got=%b required=%b", i, buzzer, exp_buzz(e.sel));
      end
      busy_cnt += int'(busy);
      done_cnt += int'(done_pulse);
    end
    total++;
    if (busy_cnt != 221) begin
      bad++;
      $display("FAIL full_busy_len got=%0d required=221", busy_cnt);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL full_done_count got=%0d required=1", done_cnt);
    end
  endtask

  task automatic test_tone_routing();
    exp_t e;
    int cnt3 = 0;
    tone_mode = 1;
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 221 + 10; i++) begin
      step_cycle();
      if (i == 3) play_button = 1'b0;
      e = model_at(GAPC, i - LEAD);
      if (e.busy && e.sel == 3) begin
        cnt3++;
        total++;
        if (buzzer !== t_old2[3]) begin
          bad++;
          $display("FAIL route_523 i=%0d got=%b required=%b", i, buzzer, t_old2[3]);
        end
      end else if (e.busy && e.sel == 4) begin
        total++;
        if (buzzer !== 1'b0) begin
          bad++;
          $display("FAIL route_silent i=%0d idx=%0d got=%b required=0", i, e.idx, buzzer);
        end
      end
    end
    total++;
    if (cnt3 != 40) begin
      bad++;
      $display("FAIL route_step3_len got=%0d required=40", cnt3);
    end
    tone_mode = 0;
  endtask

  task automatic test_stop_mid_note();
    exp_t e, idle_e;
    int i_s;
    int done_cnt = 0;
    idle_e = model_at(GAPC, -1);
    i_s = LEAD + $urandom_range(46, 63);
    play_button = 1'b1;
    for (int i = 1; i <= i_s + 40; i++) begin
      step_cycle();
      if (i == 2) play_button = 1'b0;
      e = (i >= i_s + 3) ? idle_e : model_at(GAPC, i - LEAD);
      total++;
      if (busy !== e.busy || note_idx !== 3'(e.idx) || buzzer !== exp_buzz(e.sel)) begin
        bad++;
        $display("FAIL stop_state i=%0d stop_at=%0d got busy=%b idx=%0d buz=%b required busy=%b idx=%0d buz=%b",
                 i, i_s, busy, note_idx, buzzer, e.busy, e.idx, exp_buzz(e.sel));
      end
      done_cnt += int'(done_pulse);
      if (i == i_s) stop_button = 1'b1;
      if (i == i_s + 10) play_button = 1'b1;
    end
    total++;
    if (done_cnt != 0) begin
      bad++;
      $display("FAIL stop_no_done got=%0d required=0", done_cnt);
    end
    play_button = 1'b0;
    stop_button = 1'b0;
    repeat (10) step_cycle();
  endtask

  task automatic test_ignore_retrigger();
    exp_t e;
    int i_p;
    i_p = LEAD + $urandom_range(10, 180);
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 221 + 10; i++) begin
      step_cycle();
      if (i == 2) play_button = 1'b0;
      if (i == i_p) play_button = 1'b1;
      if (i == i_p + 3) play_button = 1'b0;
      e = model_at(GAPC, i - LEAD);
      total++;
      if (busy !== e.busy || note_idx !== 3'(e.idx) || buzzer !== exp_buzz(e.sel)) begin
        bad++;
        $display("FAIL ignore_busy_press i=%0d press=%0d got busy=%b idx=%0d required busy=%b idx=%0d",
                 i, i_p, busy, note_idx, e.busy, e.idx);
      end
    end
    // held across completion: one melody only
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 221 + 30; i++) begin
      step_cycle();
      e = model_at(GAPC, i - LEAD);
      total++;
      if (busy !== e.busy || note_idx !== 3'(e.idx) || done_pulse !== e.done) begin
        bad++;
        $display("FAIL held_no_restart i=%0d got busy=%b idx=%0d done=%b required busy=%b idx=%0d done=%b",
                 i, busy, note_idx, done_pulse, e.busy, e.idx, e.done);
      end
    end
    play_button = 1'b0;
    repeat (5) step_cycle();
    // release and re-press starts a new melody
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 221 + 10; i++) begin
      step_cycle();
      if (i == 2) play_button = 1'b0;
      e = model_at(GAPC, i - LEAD);
      total++;
      if (busy !== e.busy || note_idx !== 3'(e.idx) || done_pulse !== e.done) begin
        bad++;
        $display("FAIL retrigger i=%0d got busy=%b idx=%0d done=%b required busy=%b idx=%0d done=%b",
                 i, busy, note_idx, done_pulse, e.busy, e.idx, e.done);
      end
    end
  endtask

  task automatic test_zero_gap();
    exp_t e;
    int busy_cnt = 0;
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 221 + 20; i++) begin
      step_cycle();
      if (i == 2) play_button = 1'b0;
      e = model_at(0, i - LEAD);
      total++;
      if (busy0 !== e.busy || idx0 !== 3'(e.idx) || done0 !== e.done || buzzer0 !== exp_buzz(e.sel)) begin
        bad++;
        $display("FAIL zero_gap i=%0d got busy=%b idx=%0d done=%b buz=%b required busy=%b idx=%0d done=%b buz=%b",
                 i, busy0, idx0, done0, buzzer0, e.busy, e.idx, e.done, exp_buzz(e.sel));
      end
      busy_cnt += int'(busy0);
    end
    total++;
    if (busy_cnt != 200) begin
      bad++;
      $display("FAIL zero_gap_len got=%0d required=200", busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    play_button = 1'b1;
    for (int i = 1; i <= LEAD + 50; i++) begin
      step_cycle();
      if (i == 2) play_button = 1'b0;
    end
    total++;
    if (busy !== 1'b1 || note_idx !== 3'd2) begin
      bad++;
      $display("FAIL areset_pre got busy=%b idx=%0d required busy=1 idx=2", busy, note_idx);
    end
    #3;
    reset_button = 1'b0;
    #1;
    total++;
    if ({buzzer, busy, note_idx, done_pulse, buzzer0, busy0, idx0, done0} !== 12'h000) begin
      bad++;
      $display("FAIL areset_now got=%h required=000",
               {buzzer, busy, note_idx, done_pulse, buzzer0, busy0, idx0, done0});
    end
    @(negedge clk_50MHz);
    reset_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_cycle();
      total++;
      if ({buzzer, busy, note_idx, done_pulse} !== 6'h00) begin
        bad++;
        $display("FAIL areset_after i=%0d got=%h required=00", i, {buzzer, busy, note_idx, done_pulse});
      end
    end
  endtask

  initial begin
    reset_button = 1'b0;
    play_button  = 1'b0;
    stop_button  = 1'b0;
    {clk_523Hz, clk_415Hz, clk_329Hz, clk_261Hz} = 4'h0;
    test_reset();
    test_full_melody();
    test_tone_routing();
    test_stop_mid_note();
    test_ignore_retrigger();
    test_zero_gap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Consumes the four tone clocks (261/329/415/523 Hz square waves) from the clock-divider stage and plays a fixed 8-step melody on a single buzzer output.
- Play/stop are raw board buttons, synchronized internally.
- Sits between the divider bank and the buzzer pin; all logic is on the 50 MHz clock.

Parameters:
- TICK_CYCLES, 5000000, clk_50MHz cycles per duration tick (100 ms); must be ≥1.
- GAP_CYCLES, 500000, silent cycles inserted between consecutive steps; 0 means no gap.

Ports:
- clk_50MHz  in  1  system clock.
- reset_button  in  1  asynchronous, active-low reset.
- clk_261Hz  in  1  tone square wave from the divider, registered in the clk_50MHz domain.
- clk_329Hz  in  1  tone square wave.
- clk_415Hz  in  1  tone square wave.
- clk_523Hz  in  1  tone square wave.
- play_button  in  1  raw async button, active-high.
- stop_button  in  1  raw async button, active-high.
- buzzer  out  1  selected tone, or 0 when silent.
- busy  out  1  high while in NOTE or GAP.
- note_idx  out  3  current step 0..7.
- done_pulse  out  1  one-cycle pulse on natural completion.

Behaviour:
- Reset (reset_button=0, async): state IDLE; buzzer=0, busy=0, note_idx=0, done_pulse=0; sync flops and counters cleared.
- Input conditioning:
  - play_button and stop_button each pass through 2 flops.
  - play uses rising-edge detect on the synchronized value.
  - stop uses the synchronized level.
- Melody ROM (tone, ticks):
  - 0: 261, 2
  - 1: 329, 2
  - 2: 415, 2
  - 3: 523, 4
  - 4: 415, 2
  - 5: 329, 2
  - 6: 261, 4
  - 7: REST, 2
  - Encoding is a 3-bit select: 0=261, 1=329, 2=415, 3=523, 4=REST.
- FSM states: IDLE, NOTE, GAP.
  - IDLE: on play edge with stop inactive → NOTE, note_idx=0, counters loaded.
  - NOTE: lasts exactly ticks[note_idx]*TICK_CYCLES cycles. Tick counter runs 0..TICK_CYCLES-1; a per-note tick down-counter decrements on wrap.
  - NOTE end with note_idx<7: → GAP if GAP_CYCLES>0, else straight to NOTE with note_idx+1.
  - NOTE end with note_idx=7: → IDLE, done_pulse=1 for one cycle, note_idx returns to 0.
  - GAP: lasts exactly GAP_CYCLES cycles with buzzer=0, then → NOTE with note_idx+1.
- buzzer:
  - Registered.
  - In NOTE with a non-REST tone, buzzer = selected tone input sampled on the previous edge (1-cycle latency).
  - Otherwise buzzer = 0.
- busy: registered, equals (state != IDLE).
- Latency: play_button rising, meeting setup at edge k → state NOTE and busy=1 after edge k+3 → buzzer follows the tone from edge k+4.
- Stop:
  - Synchronized stop high in NOTE or GAP → IDLE on the next edge; buzzer=0, busy=0, note_idx=0, no done_pulse.
  - Stop has priority over play when both are active.
  - Play is blocked while stop is held.
- Play edges while busy are ignored; there is no restart.
- A button held high gives exactly one play edge; re-trigger requires release and re-press.
- Counter widths must hold TICK_CYCLES-1 and GAP_CYCLES-1 without overflow.
- Reset mid-melody behaves as the reset case above, immediately and asynchronously.

Test Plan:
- Reset sanity: hold reset_button=0 while toggling all inputs → all outputs 0. Release, no buttons → outputs stay 0 for 100 cycles.
- Full melody (TICK_CYCLES=10, GAP_CYCLES=3), one play pulse:
  - busy high for exactly 221 cycles (200 NOTE + 21 GAP).
  - note_idx steps 0..7.
  - done_pulse is a single cycle at the end.
- Tone routing: drive distinct patterns on the four tone inputs.
  - Step 3 buzzer equals clk_523Hz delayed 1 cycle for 40 cycles.
  - Buzzer is 0 in every GAP and throughout step 7 (REST).
- Stop mid-note: assert stop during step 2 → IDLE 3 edges after assertion; buzzer/busy 0, note_idx 0, done_pulse never asserted.
- Ignore and re-trigger:
  - Second play press while busy → melody timing unchanged.
  - Play held high across completion → no restart.
  - Release and press → new melody starts.
- Zero gap (GAP_CYCLES=0): busy for exactly 200 cycles; note_idx advances on consecutive cycles at step boundaries.
- Async reset at cycle 50 of the melody → outputs 0 immediately, before the next clock edge.
